// File: rtl/core_loader.sv
// core_loader: framed byte-stream loader for the core setup interface (optional trailing XOR checksum via CORE_LOADER_CHECKSUM_EN)
module core_loader #(
    parameter int REG_AW = 5,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_setup,
    output logic [XLEN-1:0]   o_inst_mem_addr,
    output logic [XLEN-1:0]   o_inst_mem_data,
    output logic              o_inst_we,
    output logic [REG_AW-1:0] o_load_reg_addr,
    output logic [XLEN-1:0]   o_load_reg_data,
    output logic              o_reg_we,
    output logic [XLEN-1:0]   o_pc_start_addr,
    output logic              o_err,
    output logic              o_busy
);
    localparam int NB = XLEN / 8;
    localparam int CW = $clog2(2 * NB + 1);
    typedef enum logic [2:0] {IDLE, ARGS, CHK, EXEC, RUN} state_t;
    state_t              r_state;
    logic [7:0]          r_op;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_pay;
    logic                r_setup, r_inst_we, r_reg_we, r_err;
    logic [XLEN-1:0]     r_inst_addr, r_inst_data, r_reg_data, r_pc;
    logic [REG_AW-1:0]   r_reg_addr;
    logic                w_acc, w_last, w_fire;
    logic [CW-1:0]       w_len;
    logic [2*XLEN-1:0]   w_shift, w_pay;
    logic [XLEN-1:0]     w_lo, w_data;
    logic [REG_AW-1:0]   w_reg;
`ifdef CORE_LOADER_CHECKSUM_EN
    logic [7:0]          r_ck;
    logic                r_from_run;
`endif
    // Payload shifts in from the top, so the last field always lands in the upper word
    always_comb begin
        w_acc   = i_byte_valid && o_byte_ready;
        w_shift = {i_byte, r_pay[2*XLEN-1:8]};
        w_pay   = (r_state == ARGS) ? w_shift : r_pay;
        w_lo    = w_pay[XLEN-1:0];
        w_data  = w_pay[2*XLEN-1 -: XLEN];
        w_reg   = w_pay[XLEN-8 +: REG_AW];
        w_len   = (r_op == 8'h01) ? CW'(2 * NB) : (r_op == 8'h02) ? CW'(NB + 1) :
                  (r_op == 8'h03) ? CW'(NB) : '0;
        w_last  = r_cnt == w_len - 1'b1;
`ifdef CORE_LOADER_CHECKSUM_EN
        w_fire  = r_state == CHK && w_acc && i_byte == r_ck;
`else
        w_fire  = r_state == ARGS && w_acc && w_last;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_cnt       <= '0;
            r_pay       <= '0;
            r_setup     <= 1'b1;
            r_inst_we   <= 1'b0;
            r_reg_we    <= 1'b0;
            r_err       <= 1'b0;
            r_inst_addr <= '0;
            r_inst_data <= '0;
            r_reg_addr  <= '0;
            r_reg_data  <= '0;
            r_pc        <= '0;
`ifdef CORE_LOADER_CHECKSUM_EN
            r_ck        <= '0;
            r_from_run  <= 1'b0;
`endif
        end else begin
            r_inst_we <= 1'b0;
            r_reg_we  <= 1'b0;
            if (w_fire) begin
                if (r_op == 8'h01) begin
                    if (w_lo[1:0] == 2'b00) begin
                        r_inst_we   <= 1'b1;
                        r_inst_addr <= w_lo;
                        r_inst_data <= w_data;
                    end else
                        r_err <= 1'b1;
                end else if (r_op == 8'h02) begin
                    if (w_reg != '0) begin
                        r_reg_we   <= 1'b1;
                        r_reg_addr <= w_reg;
                        r_reg_data <= w_data;
                    end
                end else if (r_op == 8'h03) begin
                    r_pc    <= w_data;
                    r_setup <= 1'b0;
                end else
                    r_setup <= 1'b1;
            end
            case (r_state)
                IDLE: if (w_acc) begin
                    r_op  <= i_byte;
                    r_cnt <= '0;
                    if (i_byte == 8'h01 || i_byte == 8'h02 || i_byte == 8'h03)
                        r_state <= ARGS;
                    else if (i_byte != 8'h04)
                        r_err <= 1'b1;
`ifdef CORE_LOADER_CHECKSUM_EN
                    r_ck       <= i_byte;
                    r_from_run <= 1'b0;
                    if (i_byte == 8'h04)
                        r_state <= CHK;
`endif
                end
                ARGS: if (w_acc) begin
                    r_pay <= w_shift;
                    r_cnt <= r_cnt + 1'b1;
`ifdef CORE_LOADER_CHECKSUM_EN
                    r_ck <= r_ck ^ i_byte;
                    if (w_last)
                        r_state <= CHK;
`else
                    if (w_last)
                        r_state <= EXEC;
`endif
                end
`ifdef CORE_LOADER_CHECKSUM_EN
                CHK: if (w_acc) begin
                    r_state <= (i_byte == r_ck) ? EXEC : r_from_run ? RUN : IDLE;
                    if (i_byte != r_ck)
                        r_err <= 1'b1;
                end
`endif
                EXEC: r_state <= (r_op == 8'h03) ? RUN : IDLE;
                RUN: if (w_acc && i_byte == 8'h04) begin
`ifdef CORE_LOADER_CHECKSUM_EN
                    r_op       <= 8'h04;
                    r_ck       <= 8'h04;
                    r_from_run <= 1'b1;
                    r_state    <= CHK;
`else
                    r_setup <= 1'b1;
                    r_state <= IDLE;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_byte_ready    = r_state != EXEC;
    assign o_busy          = !(r_state == IDLE || r_state == RUN);
    assign o_setup         = r_setup;
    assign o_inst_mem_addr = r_inst_addr;
    assign o_inst_mem_data = r_inst_data;
    assign o_inst_we       = r_inst_we;
    assign o_load_reg_addr = r_reg_addr;
    assign o_load_reg_data = r_reg_data;
    assign o_reg_we        = r_reg_we;
    assign o_pc_start_addr = r_pc;
    assign o_err           = r_err;
endmodule
